// File: rtl/srl_fifo.sv
// Shallow FIFO on a shift-register array; the read tap follows the occupancy count.
// Optional SRL_FIFO_LEVEL_EN adds the level and registered almost_full outputs.
module srl_fifo #(
    parameter int SRL_WIDTH = 18,
    parameter int SRL_DEPTH = 32,
    parameter int AF_LEVEL  = 28
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [SRL_WIDTH-1:0]             s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [SRL_WIDTH-1:0]             m_data
`ifdef SRL_FIFO_LEVEL_EN
    ,
    output logic [$clog2(SRL_DEPTH+1)-1:0]   level,
    output logic                             almost_full
`endif
);

    localparam int CW = $clog2(SRL_DEPTH + 1);
    localparam int IW = $clog2(SRL_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(SRL_DEPTH);

    if (SRL_DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > SRL_DEPTH) begin : g_bad_param
        $error("srl_fifo: illegal SRL_DEPTH/AF_LEVEL");
    end

    logic [SRL_WIDTH-1:0] mem [SRL_DEPTH];
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic [IW-1:0]        rd_idx;
    logic                 push;
    logic                 pop;

    assign s_ready = !rst && (count != FULL_CNT);
    assign m_valid = (count != '0);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count_nxt;
    end

    // Storage carries no reset so it can map onto SRL primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= s_data;
            for (int i = 1; i < SRL_DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    // Oldest word sits at count-1; the value at count==0 is don't-care.
    assign rd_idx = IW'(count - 1'b1);

    always_comb begin
        m_data = mem[rd_idx];
    end

`ifdef SRL_FIFO_LEVEL_EN
    assign level = count;

    always_ff @(posedge clk) begin
        if (rst)
            almost_full <= 1'b0;
        else
            almost_full <= (count_nxt >= CW'(AF_LEVEL));
    end
`endif

endmodule

// File: tb/tb_srl_fifo.sv
// Self-checking bench for srl_fifo: queue-based reference model checked every cycle
// plus literal expectations at the test-plan milestones.
module tb_srl_fifo;

    localparam int W     = 18;
    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
`ifdef SRL_FIFO_LEVEL_EN
    logic [CW-1:0] level;
    logic          almost_full;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    logic         af_model = 1'b0;

    srl_fifo #(.SRL_WIDTH(W), .SRL_DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
`ifdef SRL_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue updated from the handshake rules at each rising edge.
    always @(posedge clk) begin
        bit do_push, do_pop;
        do_push = s_valid && !rst && (q.size() != DEPTH);
        do_pop  = m_ready && (q.size() != 0);
        if (rst) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(s_data);
        end
        af_model = !rst && (q.size() >= AF);
    end

    // Outputs are checked mid-cycle, well away from the active edge.
    always @(negedge clk) begin
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        chk("s_ready", 32'(s_ready), 32'(!rst && q.size() != DEPTH));
        if (q.size() != 0)
            chk("m_data", 32'(m_data), 32'(q[0]));
`ifdef SRL_FIFO_LEVEL_EN
        chk("level", 32'(level), 32'(q.size()));
        chk("almost_full", 32'(almost_full), 32'(af_model));
`endif
    end

    task automatic step(input logic sv, input logic [W-1:0] d, input logic mr);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Fill with 1..32, consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, W'(i + 1), 1'b0);
`ifdef SRL_FIFO_LEVEL_EN
            if (i + 1 == AF - 1) chk("af_below", 32'(almost_full), 32'd0);
            if (i + 1 == AF)     chk("af_at",    32'(almost_full), 32'd1);
`endif
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_m_valid", 32'(m_valid), 32'd1);
        chk("full_head",    32'(m_data),  32'h1);
`ifdef SRL_FIFO_LEVEL_EN
        chk("full_level",   32'(level),   32'd32);
`endif

        // Drain in order.
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b1);
        chk("drain_s_ready", 32'(s_ready), 32'd1);
        chk("drain_2nd",     32'(m_data),  32'h2);
        for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        chk("drained_m_valid", 32'(m_valid), 32'd0);

        // Streaming from empty.
        step(1'b1, W'('h100), 1'b1);
        chk("stream_first_valid", 32'(m_valid), 32'd1);
        chk("stream_first_data",  32'(m_data),  32'h100);
        for (int i = 1; i < 20; i++) begin
            step(1'b1, W'('h100 + i), 1'b1);
            chk("stream_data", 32'(m_data), 32'('h100 + i));
`ifdef SRL_FIFO_LEVEL_EN
            chk("stream_level", 32'(level), 32'd1);
`endif
        end
        step(1'b0, '0, 1'b1);
        chk("stream_empty", 32'(m_valid), 32'd0);

        // Full with simultaneous pop.
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'('h200 + i), 1'b0);
        step(1'b1, W'('h220), 1'b1);
        chk("fullpop_s_ready", 32'(s_ready), 32'd1);
        chk("fullpop_head",    32'(m_data),  32'h201);
        step(1'b1, W'('h220), 1'b1);
        chk("fullpop_head2",   32'(m_data),  32'h202);
        step(1'b1, W'('h221), 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);
        chk("fullpop_empty", 32'(m_valid), 32'd0);

        // Random backpressure.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);

        // Reset mid-operation at 17 entries.
        for (int i = 0; i < 17; i++) step(1'b1, W'('h3000 + i), 1'b0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        #4;
        step(1'b1, W'('h3ABC), 1'b0);
        chk("midrst_readback", 32'(m_data), 32'h3ABC);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
